// File: rtl/oc15_pkg.sv
// Shared widths and types for the oc15 ones counter.
package oc15_pkg;

   localparam int IN_W  = 15;
   localparam int OUT_W = 4;

   typedef logic [OUT_W-1:0] cnt_t;

endpackage : oc15_pkg

// File: rtl/full_adder.sv
// Single-bit full adder, the only building block of the oc15 compressor tree.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic axb;

   assign axb  = a ^ b;
   assign sum  = axb ^ cin;
   assign cout = (a & b) | (cin & axb);

endmodule : full_adder

// File: rtl/oc15.sv
// 15-bit population count: full-adder compressor tree feeding one output register.
module oc15
   import oc15_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [0:IN_W-1] in,
   input  logic            in_valid,
   output logic [OUT_W-1:0] out,
   output logic            out_valid
);

   logic [2:0] pa;
   logic [2:0] pb;
   logic       sa1, ca1, sa2, ca2, ca3;
   logic       sb1, cb1, sb2, cb2, cb3;
   logic       rc0, rc1;
   cnt_t       cnt_p0;
   cnt_t       cnt_p1;
   logic       vld_p1;

   // stage p0: two 7:3 counters over in[0:6] and in[7:13]
   full_adder u_fa_a1 (.a(in[0]), .b(in[1]), .cin(in[2]), .sum(sa1),   .cout(ca1));
   full_adder u_fa_a2 (.a(in[3]), .b(in[4]), .cin(in[5]), .sum(sa2),   .cout(ca2));
   full_adder u_fa_a3 (.a(sa1),   .b(sa2),   .cin(in[6]), .sum(pa[0]), .cout(ca3));
   full_adder u_fa_a4 (.a(ca1),   .b(ca2),   .cin(ca3),   .sum(pa[1]), .cout(pa[2]));

   full_adder u_fa_b1 (.a(in[7]),  .b(in[8]),  .cin(in[9]),  .sum(sb1),   .cout(cb1));
   full_adder u_fa_b2 (.a(in[10]), .b(in[11]), .cin(in[12]), .sum(sb2),   .cout(cb2));
   full_adder u_fa_b3 (.a(sb1),    .b(sb2),    .cin(in[13]), .sum(pb[0]), .cout(cb3));
   full_adder u_fa_b4 (.a(cb1),    .b(cb2),    .cin(cb3),    .sum(pb[1]), .cout(pb[2]));

   // the 15th bit enters as carry-in of the ripple adder that merges the partial counts
   full_adder u_fa_r0 (.a(pa[0]), .b(pb[0]), .cin(in[14]), .sum(cnt_p0[0]), .cout(rc0));
   full_adder u_fa_r1 (.a(pa[1]), .b(pb[1]), .cin(rc0),    .sum(cnt_p0[1]), .cout(rc1));
   full_adder u_fa_r2 (.a(pa[2]), .b(pb[2]), .cin(rc1),    .sum(cnt_p0[2]), .cout(cnt_p0[3]));

   // stage p1: output register, count held while in_valid is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_p1 <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid)
            cnt_p1 <= cnt_p0;
      end
   end

   assign out       = cnt_p1;
   assign out_valid = vld_p1;

endmodule : oc15

// File: tb/tb_oc15.sv
// Directed and exhaustive self-checking bench for oc15.
module tb_oc15;

   logic        clk;
   logic        rst_n;
   logic [0:14] in;
   logic        in_valid;
   logic [3:0]  out;
   logic        out_valid;

   int n_cmp;
   int n_err;

   oc15 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in),
      .in_valid  (in_valid),
      .out       (out),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] model_pop(input logic [14:0] w);
      logic [3:0] c;
      c = 4'd0;
      for (int b = 0; b < 15; b++)
         if (w[b]) c = c + 4'd1;
      return c;
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // drive a word, let one rising edge sample it, settle 1 time unit past the edge
   task automatic apply(input logic [14:0] w, input logic v);
      in       = w;
      in_valid = v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [14:0] w;
      n_cmp    = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      in       = 15'h7FFF;
      in_valid = 1'b1;

      // reset dominates a valid all-ones word
      @(posedge clk);
      #1;
      check("rst_out", out, 4'd0);
      check("rst_vld", {3'b0, out_valid}, 4'd1 - 4'd1);
      rst_n = 1'b1;
      apply(15'h7FFF, 1'b1);
      check("rst_rel_out", out, 4'd15);
      check("rst_rel_vld", {3'b0, out_valid}, 4'd1);

      // thermometer sweep 0..15 ones
      for (int k = 0; k <= 15; k++) begin
         w = 15'((16'd1 << k) - 16'd1);
         apply(w, 1'b1);
         check("therm_out", out, 4'(k));
         check("therm_vld", {3'b0, out_valid}, 4'd1);
      end

      // position independence
      apply(15'b101010101010101, 1'b1);
      check("pos_a", out, 4'd8);
      apply(15'b010101010101010, 1'b1);
      check("pos_5", out, 4'd7);
      apply(15'b100000000000000, 1'b1);
      check("pos_msb", out, 4'd1);
      apply(15'b000000000000001, 1'b1);
      check("pos_lsb", out, 4'd1);
      apply(15'b000000000000000, 1'b1);
      check("zero", out, 4'd0);

      // hold with in_valid low, including unknown input bits
      apply(15'b000000000011111, 1'b1);
      check("hold_load", out, 4'd5);
      for (int k = 0; k < 3; k++) begin
         apply(15'h7FFF, 1'b0);
         check("hold_out", out, 4'd5);
         check("hold_vld", {3'b0, out_valid}, 4'd0);
      end
      apply('x, 1'b0);
      check("hold_x", out, 4'd5);

      // asynchronous reset between edges
      apply(15'b000000111111111, 1'b1);
      check("mid_load", out, 4'd9);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_out", out, 4'd0);
      check("async_vld", {3'b0, out_valid}, 4'd0);
      @(negedge clk);
      rst_n = 1'b1;
      apply(15'b110000000000011, 1'b1);
      check("post_rst", out, 4'd4);
      check("post_rst_vld", {3'b0, out_valid}, 4'd1);

      // exhaustive back-to-back
      for (int i = 0; i < 32768; i++) begin
         w = 15'(i);
         apply(w, 1'b1);
         check("exh", out, model_pop(w));
      end
      check("exh_vld", {3'b0, out_valid}, 4'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_oc15
